// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the OP-IMM instruction sequencer.
//   state_t  : sequencer FSM states
//   alu_op_t : ALU operation select driven to the datapath
//   OPC_* / F3_* / F7_* : RV32I encoding constants used by the decoder
package rv_ctrl_pkg;

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExecute,
      StWriteback,
      StTrap
   } state_t;

   typedef enum logic [3:0] {
      AluAdd  = 4'd0,
      AluSlt  = 4'd1,
      AluSltu = 4'd2,
      AluXor  = 4'd3,
      AluOr   = 4'd4,
      AluAnd  = 4'd5,
      AluSll  = 4'd6,
      AluSrl  = 4'd7,
      AluSra  = 4'd8
   } alu_op_t;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRX  = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_SRA  = 7'b0100000;

endpackage

// File: rtl/itype_decoder.sv
// Combinational OP-IMM decoder.
//   instr   in   32    instruction word
//   rs1     out  5     source register
//   rd      out  5     destination register
//   imm     out  XLEN  sign-extended imm[11:0], or zero-extended shamt for shifts
//   alu_op  out  4     ALU operation
//   illegal out  1     encoding is not a supported OP-IMM instruction
module itype_decoder
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [4:0]      rs1,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] imm,
   output alu_op_t         alu_op,
   output logic            illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       is_shift;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign funct7   = instr[31:25];
   assign rs1      = instr[19:15];
   assign rd       = instr[11:7];
   assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRX);

   assign imm = is_shift ? {{(XLEN-5){1'b0}}, instr[24:20]}
                         : {{(XLEN-12){instr[31]}}, instr[31:20]};

   always_comb begin
      alu_op  = AluAdd;
      illegal = (opcode != OPC_OP_IMM);
      unique case (funct3)
         F3_ADD:  alu_op = AluAdd;
         F3_SLT:  alu_op = AluSlt;
         F3_SLTU: alu_op = AluSltu;
         F3_XOR:  alu_op = AluXor;
         F3_OR:   alu_op = AluOr;
         F3_AND:  alu_op = AluAnd;
         F3_SLL: begin
            alu_op = AluSll;
            if (funct7 != F7_ZERO) illegal = 1'b1;
         end
         F3_SRX: begin
            // funct7 picks logical vs arithmetic; anything else is reserved
            if (funct7 == F7_ZERO) begin
               alu_op = AluSrl;
            end else if (funct7 == F7_SRA) begin
               alu_op = AluSra;
            end else begin
               alu_op  = AluSrl;
               illegal = 1'b1;
            end
         end
         default: alu_op = AluAdd;
      endcase
   end

endmodule

// File: rtl/rv_itype_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for RV32I OP-IMM instructions.
//   clk, rst               clock, synchronous active-high reset
//   imem_req/addr          fetch request and address (held until imem_valid)
//   imem_valid/rdata       fetch response
//   rs1_addr, rd_addr      register-bank read/write addresses
//   imm, alu_op            ALU operand B and operation
//   reg_we                 register-bank write enable (1-cycle pulse, never while rst)
//   pc_out                 current PC
//   retired                1-cycle pulse per completed instruction
//   illegal                high while trapped on an unsupported encoding
module rv_itype_sequencer
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned    XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [31:0]     imem_rdata,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] imm,
   output logic [3:0]      alu_op,
   output logic            reg_we,
   output logic [XLEN-1:0] pc_out,
   output logic            retired,
   output logic            illegal
);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q;
   logic [31:0]     instr_q;
   logic [4:0]      rs1_q, rd_q;
   logic [XLEN-1:0] imm_q;
   alu_op_t         alu_op_q;

   logic [4:0]      dec_rs1, dec_rd;
   logic [XLEN-1:0] dec_imm;
   alu_op_t         dec_alu_op;
   logic            dec_illegal;

   itype_decoder #(
      .XLEN (XLEN)
   ) u_decoder (
      .instr   (instr_q),
      .rs1     (dec_rs1),
      .rd      (dec_rd),
      .imm     (dec_imm),
      .alu_op  (dec_alu_op),
      .illegal (dec_illegal)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= StFetch;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch:     if (imem_valid) state_d = StDecode;
         StDecode:    state_d = dec_illegal ? StTrap : StExecute;
         StExecute:   state_d = StWriteback;
         StWriteback: state_d = StFetch;
         StTrap:      state_d = StTrap;
         default:     state_d = StFetch;
      endcase
   end

   // Outputs; write and retire are masked by rst so a reset in WRITEBACK drops them
   always_comb begin
      imem_req = (state_q == StFetch);
      reg_we   = (state_q == StWriteback) && (rd_q != 5'd0) && !rst;
      retired  = (state_q == StWriteback) && !rst;
      illegal  = (state_q == StTrap);
   end

   // PC, fetched word and decoded fields; fields hold from DECODE until the next DECODE
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         instr_q  <= '0;
         rs1_q    <= '0;
         rd_q     <= '0;
         imm_q    <= '0;
         alu_op_q <= AluAdd;
      end else begin
         if (state_q == StFetch && imem_valid) instr_q <= imem_rdata;
         if (state_q == StDecode && !dec_illegal) begin
            rs1_q    <= dec_rs1;
            rd_q     <= dec_rd;
            imm_q    <= dec_imm;
            alu_op_q <= dec_alu_op;
         end
         if (state_q == StWriteback) pc_q <= pc_q + XLEN'(4);
      end
   end

   assign imem_addr = pc_q;
   assign pc_out    = pc_q;
   assign rs1_addr  = rs1_q;
   assign rd_addr   = rd_q;
   assign imm       = imm_q;
   assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_rv_itype_sequencer.sv
// Scoreboard bench for rv_itype_sequencer: expected decode results are queued as each
// instruction is handed to the fetch port and compared when the retire pulse appears.
module tb_rv_itype_sequencer;

   localparam int unsigned XLEN = 32;

   // ALU op codes in the order the operation list defines them
   localparam logic [3:0] OP_ADD = 4'd0, OP_SLT = 4'd1, OP_SLTU = 4'd2, OP_XOR = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4, OP_AND = 4'd5, OP_SLL  = 4'd6, OP_SRL = 4'd7;
   localparam logic [3:0] OP_SRA = 4'd8;

   typedef struct {
      logic [4:0]  rs1;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  op;
      logic        we;
      logic [31:0] pc;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_valid = 1'b0;
   logic [31:0]     imem_rdata = '0;
   logic [4:0]      rs1_addr, rd_addr;
   logic [XLEN-1:0] imm;
   logic [3:0]      alu_op;
   logic            reg_we;
   logic [XLEN-1:0] pc_out;
   logic            retired;
   logic            illegal;

   int n_cmp = 0;
   int n_err = 0;
   int retire_cnt = 0;
   int we_cnt = 0;
   int exp_retire = 0;
   int exp_we = 0;
   logic [31:0] tb_pc = '0;
   exp_t sb[$];

   always #5 clk = ~clk;

   rv_itype_sequencer #(
      .XLEN     (XLEN),
      .RESET_PC (32'h0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_rdata (imem_rdata),
      .rs1_addr   (rs1_addr),
      .rd_addr    (rd_addr),
      .imm        (imm),
      .alu_op     (alu_op),
      .reg_we     (reg_we),
      .pc_out     (pc_out),
      .retired    (retired),
      .illegal    (illegal)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk_exp(input logic [4:0] rs1, input logic [4:0] rd,
                                   input logic [31:0] im, input logic [3:0] op);
      exp_t e;
      e.rs1 = rs1;
      e.rd  = rd;
      e.imm = im;
      e.op  = op;
      e.we  = (rd != 5'd0);
      e.pc  = tb_pc;
      return e;
   endfunction

   // Hand one instruction to the fetch port after 'waits' stall cycles. Entered and left
   // on a falling edge; leaves with the DUT in DECODE.
   task automatic fetch(input logic [31:0] ins, input int waits, input bit push, input exp_t e);
      int n = 0;
      while (!imem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("fetch_req", {31'd0, imem_req}, 32'd1);
      check("fetch_addr", imem_addr, tb_pc);
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         check("stall_req", {31'd0, imem_req}, 32'd1);
         check("stall_addr", imem_addr, tb_pc);
      end
      imem_valid = 1'b1;
      imem_rdata = ins;
      if (push) begin
         sb.push_back(e);
         exp_retire++;
         if (e.we) exp_we++;
      end
      @(negedge clk);
      imem_valid = 1'b0;
      imem_rdata = $urandom;
   endtask

   // Scoreboard side: compare on every retire pulse
   always @(negedge clk) begin
      if (reg_we) begin
         we_cnt++;
         check("we_without_retire", {31'd0, retired}, 32'd1);
      end
      if (retired) begin
         retire_cnt++;
         if (sb.size() == 0) begin
            check("sb_unexpected_retire", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rs1_addr", {27'd0, rs1_addr}, {27'd0, e.rs1});
            check("rd_addr", {27'd0, rd_addr}, {27'd0, e.rd});
            check("imm", imm, e.imm);
            check("alu_op", {28'd0, alu_op}, {28'd0, e.op});
            check("reg_we", {31'd0, reg_we}, {31'd0, e.we});
            check("retire_pc", pc_out, e.pc);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      exp_t dummy;
      int seg_retire;
      dummy = mk_exp(5'd0, 5'd0, 32'd0, OP_ADD);

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req", {31'd0, imem_req}, 32'd1);
      check("rst_pc", pc_out, 32'd0);
      check("rst_we", {31'd0, reg_we}, 32'd0);
      check("rst_retired", {31'd0, retired}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      check("rst_imm", imm, 32'd0);
      rst = 1'b0;

      // ADDI x3,x13,34 with two wait states; retire lands three edges after valid
      fetch(32'h02268193, 2, 1'b1, mk_exp(5'd13, 5'd3, 32'd34, OP_ADD));
      @(negedge clk);
      check("lat_exec_retired", {31'd0, retired}, 32'd0);
      @(negedge clk);
      check("lat_wb_retired", {31'd0, retired}, 32'd1);
      check("lat_wb_we", {31'd0, reg_we}, 32'd1);
      tb_pc += 4;
      @(negedge clk);
      check("pc_after_addi", pc_out, 32'd4);

      // SRAI x12,x1,2 then SRLI x27,x12,1
      fetch(32'h4020d613, 0, 1'b1, mk_exp(5'd1, 5'd12, 32'd2, OP_SRA));
      tb_pc += 4;
      fetch(32'h00165d93, 1, 1'b1, mk_exp(5'd12, 5'd27, 32'd1, OP_SRL));
      tb_pc += 4;

      // ADDI x0,x0,1: retires without a write
      fetch(32'h00100013, 0, 1'b1, mk_exp(5'd0, 5'd0, 32'd1, OP_ADD));
      tb_pc += 4;
      // negative immediate sign-extends
      fetch(32'hfff0c093, 0, 1'b1, mk_exp(5'd1, 5'd1, 32'hffffffff, OP_XOR));
      tb_pc += 4;

      // Reset asserted during WRITEBACK: write and retire must be dropped
      fetch(32'h00700293, 0, 1'b0, dummy);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("wb_rst_we", {31'd0, reg_we}, 32'd0);
      check("wb_rst_retired", {31'd0, retired}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("wb_rst_pc", pc_out, 32'd0);
      check("wb_rst_req", {31'd0, imem_req}, 32'd1);
      tb_pc = '0;

      // 17 OP-IMM instructions, the first one stalled for 5 cycles
      seg_retire = retire_cnt;
      for (int i = 0; i < 17; i++) begin
         logic [2:0]  f3;
         logic [4:0]  r1, rd, sh;
         logic [11:0] i12;
         logic        sra;
         logic [31:0] eimm;
         logic [3:0]  op;
         f3  = 3'($urandom_range(0, 7));
         r1  = 5'($urandom);
         rd  = 5'($urandom);
         sh  = 5'($urandom);
         sra = 1'($urandom);
         i12 = 12'($urandom);
         if (f3 == 3'd1) i12 = {7'd0, sh};
         if (f3 == 3'd5) i12 = {1'b0, sra, 5'd0, sh};
         eimm = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, sh} : {{20{i12[11]}}, i12};
         case (f3)
            3'd0: op = OP_ADD;
            3'd2: op = OP_SLT;
            3'd3: op = OP_SLTU;
            3'd4: op = OP_XOR;
            3'd6: op = OP_OR;
            3'd7: op = OP_AND;
            3'd1: op = OP_SLL;
            default: op = sra ? OP_SRA : OP_SRL;
         endcase
         e = mk_exp(r1, rd, eimm, op);
         fetch({i12, r1, f3, rd, 7'b0010011}, (i == 0) ? 5 : 0, 1'b1, e);
         tb_pc += 4;
      end
      begin
         int n = 0;
         while (!imem_req && n < 10) begin
            @(negedge clk);
            n++;
         end
      end
      check("burst_pc", pc_out, 32'd68);
      check("burst_retired", retire_cnt - seg_retire, 17);

      // SRLI with funct7=0000001 traps
      fetch(32'h0220d613, 0, 1'b0, dummy);
      @(negedge clk);
      check("trap_illegal", {31'd0, illegal}, 32'd1);
      imem_valid = 1'b1;
      imem_rdata = 32'h00100093;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("trap_req", {31'd0, imem_req}, 32'd0);
         check("trap_pc", pc_out, 32'd68);
         check("trap_sticky", {31'd0, illegal}, 32'd1);
      end
      imem_valid = 1'b0;

      // Only reset leaves the trap
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("trap_rst_illegal", {31'd0, illegal}, 32'd0);
      check("trap_rst_req", {31'd0, imem_req}, 32'd1);
      check("trap_rst_pc", pc_out, 32'd0);

      repeat (2) @(negedge clk);
      check("sb_drained", sb.size(), 32'd0);
      check("retire_total", retire_cnt, exp_retire);
      check("we_total", we_cnt, exp_we);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
